// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot-time program loader in front of the CPU instruction memory. A byte
// stream (valid/ready) carries a 4-byte little-endian word count N followed by
// N little-endian 32-bit words. Each completed word is written to instruction
// memory at LOAD_BASE + 4*k. The CPU is held in reset until the last word has
// been written.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_byte_data    stream byte
//   i_byte_valid   i_byte_data is valid
//   o_byte_ready   loader accepts a byte (transfer on valid && ready)
//   o_imem_we      one-cycle instruction memory write strobe
//   o_imem_addr    byte address of the write
//   o_imem_wdata   assembled instruction word
//   o_cpu_reset_n  active-low CPU reset, released once the load completes
//   o_load_done    program fully written (sticky until reset)
//   o_load_error   header rejected (sticky until reset)
//   o_words_loaded number of words written so far
// ----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int INSTR_MEM_DEPTH = 256,
  parameter int LOAD_BASE       = 0
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic [7:0]                          i_byte_data,
  input  logic                                i_byte_valid,
  output logic                                o_byte_ready,
  output logic                                o_imem_we,
  output logic [$clog2(INSTR_MEM_DEPTH)-1:0]  o_imem_addr,
  output logic [DATA_WIDTH-1:0]               o_imem_wdata,
  output logic                                o_cpu_reset_n,
  output logic                                o_load_done,
  output logic                                o_load_error,
  output logic [$clog2(INSTR_MEM_DEPTH/4):0]  o_words_loaded
);

  localparam int AW  = $clog2(INSTR_MEM_DEPTH);
  localparam int WCW = $clog2(INSTR_MEM_DEPTH / 4) + 1;
  // Largest word count that still fits between LOAD_BASE and the memory end.
  localparam logic [31:0] MAX_WORDS = 32'((INSTR_MEM_DEPTH - LOAD_BASE) / 4);

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state, state_n;
  logic [1:0]       byte_idx;
  logic [31:0]      hdr;
  logic [23:0]      asm_lo;
  logic [WCW-1:0]   word_cnt;
  logic             accept;
  logic [31:0]      hdr_full;
  logic             last_word;
  logic             ready_n;
  logic             done_n;
  logic             err_n;

  assign accept    = i_byte_valid && o_byte_ready;
  // Header value as it will be once the byte currently on the bus lands in
  // bits 31:24; used to decide the next state on the 4th header byte.
  assign hdr_full  = {i_byte_data, hdr[23:0]};
  assign last_word = (32'(word_cnt) == hdr - 32'd1);

  // State register plus registered outputs.
  // NOTE: every flop here uses <= so all state updates see the pre-edge values
  // of each other; blocking assignments would make results depend on order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_HDR;
      o_byte_ready  <= 1'b0;
      o_cpu_reset_n <= 1'b0;
      o_load_done   <= 1'b0;
      o_load_error  <= 1'b0;
    end else begin
      state         <= state_n;
      o_byte_ready  <= ready_n;
      o_cpu_reset_n <= done_n;
      o_load_done   <= done_n;
      o_load_error  <= err_n;
    end
  end

  // Next-state logic.
  // NOTE: state_n gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_HDR: begin
        if (accept && byte_idx == 2'd3) begin
          if (hdr_full == 32'd0)           state_n = S_DONE;
          else if (hdr_full > MAX_WORDS)   state_n = S_ERR;
          else                             state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_idx == 2'd3 && last_word) state_n = S_DONE;
      end
      S_DONE:  state_n = S_DONE;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_HDR;
    endcase
  end

  // Output decode. Ready follows the upcoming state so it drops on the same
  // edge that completes the load; done/error follow the current state so they
  // rise one edge after the transition, i.e. after the final write strobe.
  always_comb begin
    ready_n = (state_n == S_HDR) || (state_n == S_DATA);
    done_n  = (state == S_DONE);
    err_n   = (state == S_ERR);
  end

  // Byte assembly, write strobe and word counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byte_idx     <= 2'd0;
      hdr          <= '0;
      asm_lo       <= '0;
      word_cnt     <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
    end else begin
      o_imem_we <= 1'b0;
      if (accept) begin
        // Index only advances on a real transfer, so valid gaps lose nothing.
        byte_idx <= byte_idx + 2'd1;
        if (state == S_HDR) begin
          hdr[{byte_idx, 3'b000} +: 8] <= i_byte_data;
          if (byte_idx == 2'd3) word_cnt <= '0;
        end else if (state == S_DATA) begin
          if (byte_idx != 2'd3) begin
            asm_lo[{byte_idx, 3'b000} +: 8] <= i_byte_data;
          end else begin
            o_imem_we    <= 1'b1;
            o_imem_addr  <= AW'(LOAD_BASE) + AW'({word_cnt, 2'b00});
            o_imem_wdata <= DATA_WIDTH'({i_byte_data, asm_lo});
            word_cnt     <= word_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign o_words_loaded = word_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader. Two instances share the byte bus:
// dut0 with LOAD_BASE=0 and dut1 with LOAD_BASE=80; sel picks which one
// receives valid and which one the monitor observes.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_data;
  logic        vld;
  logic        sel;

  logic        valid0, valid1;
  logic        ready0, we0, cpu0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [6:0]  words0;
  logic        ready1, we1, cpu1, done1, err1;
  logic [7:0]  addr1;
  logic [31:0] wdata1;
  logic [6:0]  words1;

  assign valid0 = vld & ~sel;
  assign valid1 = vld & sel;

  imem_boot_loader #(.DATA_WIDTH(32), .INSTR_MEM_DEPTH(256), .LOAD_BASE(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_byte_data(byte_data), .i_byte_valid(valid0),
    .o_byte_ready(ready0), .o_imem_we(we0), .o_imem_addr(addr0), .o_imem_wdata(wdata0),
    .o_cpu_reset_n(cpu0), .o_load_done(done0), .o_load_error(err0), .o_words_loaded(words0)
  );

  imem_boot_loader #(.DATA_WIDTH(32), .INSTR_MEM_DEPTH(256), .LOAD_BASE(80)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_byte_data(byte_data), .i_byte_valid(valid1),
    .o_byte_ready(ready1), .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_wdata(wdata1),
    .o_cpu_reset_n(cpu1), .o_load_done(done1), .o_load_error(err1), .o_words_loaded(words1)
  );

  // Outputs of the currently selected instance.
  logic        ready_s, we_s, cpu_s, done_s, err_s;
  logic [7:0]  addr_s;
  logic [31:0] wdata_s;
  logic [6:0]  words_s;
  assign ready_s = sel ? ready1 : ready0;
  assign we_s    = sel ? we1    : we0;
  assign cpu_s   = sel ? cpu1   : cpu0;
  assign done_s  = sel ? done1  : done0;
  assign err_s   = sel ? err1   : err0;
  assign addr_s  = sel ? addr1  : addr0;
  assign wdata_s = sel ? wdata1 : wdata0;
  assign words_s = sel ? words1 : words0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  done_cyc;
  int  cpu_cyc;
  int  acc;

  // Monitor at the falling edge: inputs only change just after a rising edge,
  // so valid && ready seen here is exactly the transfer at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete();
      done_cyc <= -1;
      cpu_cyc  <= -1;
      acc      <= 0;
    end else begin
      if (we_s) wq.push_back('{addr: addr_s, data: wdata_s, cyc: cyc});
      if (done_s && done_cyc < 0) done_cyc <= cyc;
      if (cpu_s && cpu_cyc < 0)   cpu_cyc  <= cyc;
      if (vld && ready_s)         acc      <= acc + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic s);
    vld   = 1'b0;
    sel   = s;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    bit  got;
    vld = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_data = b;
    vld       = 1'b1;
    n         = 0;
    got       = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (ready_s) got = 1'b1;
      else n++;
    end
    if (!got) check("byte_timeout", 32'(got), 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (gmax == 0) ? 0 : int'($urandom_range(1, gmax)));
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done_s || err_s) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("wait_timeout", 32'(done_s | err_s), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Two-word program, either back-to-back or with random valid gaps.
  task automatic run_two_words(input string tag, input int gmax);
    do_reset(1'b0);
    send_word(32'd2, gmax);
    send_word(32'h0050_0513, gmax);
    send_word(32'h01EF_0213, gmax);
    wait_end();
    check({tag, "_nwr"}, 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check({tag, "_addr0"}, 32'(wq[0].addr), 32'd0);
      check({tag, "_data0"}, wq[0].data, 32'h0050_0513);
      check({tag, "_addr1"}, 32'(wq[1].addr), 32'd4);
      check({tag, "_data1"}, wq[1].data, 32'h01EF_0213);
      check({tag, "_done_lat"}, 32'(done_cyc - wq[1].cyc), 32'd1);
      check({tag, "_cpu_lat"}, 32'(cpu_cyc - wq[1].cyc), 32'd1);
      if (gmax == 0) check({tag, "_spacing"}, 32'(wq[1].cyc - wq[0].cyc), 32'd4);
    end
    check({tag, "_words"}, 32'(words_s), 32'd2);
    check({tag, "_cpu"}, 32'(cpu_s), 32'd1);
    check({tag, "_ready"}, 32'(ready_s), 32'd0);
    check({tag, "_acc"}, 32'(acc), 32'd12);
  endtask

  int acc_cyc;

  initial begin
    rst_n     = 1'b0;
    vld       = 1'b0;
    sel       = 1'b0;
    byte_data = 8'h00;

    // Reset values while reset is held.
    #12;
    check("rst_ready",  32'(ready0), 32'd0);
    check("rst_we",     32'(we0),    32'd0);
    check("rst_addr",   32'(addr0),  32'd0);
    check("rst_wdata",  wdata0,      32'd0);
    check("rst_cpu",    32'(cpu0),   32'd0);
    check("rst_done",   32'(done0),  32'd0);
    check("rst_err",    32'(err0),   32'd0);
    check("rst_words",  32'(words0), 32'd0);
    check("rst_ready1", 32'(ready1), 32'd0);

    // First cycle after release: HDR, ready.
    do_reset(1'b0);
    check("hdr_ready", 32'(ready0), 32'd1);

    run_two_words("b2b", 0);
    run_two_words("gaps", 7);

    // N == 0: immediate completion, no writes, further bytes refused.
    do_reset(1'b0);
    send_word(32'd0, 0);
    acc_cyc = cyc;
    vld     = 1'b1;
    repeat (6) @(negedge clk);
    vld = 1'b0;
    check("n0_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
    check("n0_done", 32'(done0), 32'd1);
    check("n0_cpu", 32'(cpu0), 32'd1);
    check("n0_nwr", 32'(wq.size()), 32'd0);
    check("n0_acc", 32'(acc), 32'd4);
    check("n0_ready", 32'(ready0), 32'd0);

    // N == 65 does not fit 64 words: error.
    do_reset(1'b0);
    send_word(32'd65, 0);
    wait_end();
    check("n65_err", 32'(err0), 32'd1);
    check("n65_cpu", 32'(cpu0), 32'd0);
    check("n65_done", 32'(done0), 32'd0);
    check("n65_ready", 32'(ready0), 32'd0);
    check("n65_nwr", 32'(wq.size()), 32'd0);
    do_reset(1'b0);
    check("n65_recover_err", 32'(err0), 32'd0);
    check("n65_recover_ready", 32'(ready0), 32'd1);

    // LOAD_BASE = 80, N = 3.
    do_reset(1'b1);
    send_word(32'd3, 0);
    send_word(32'h1111_0001, 0);
    send_word(32'h2222_0002, 0);
    send_word(32'h3333_0003, 0);
    wait_end();
    check("b80_nwr", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      check("b80_addr0", 32'(wq[0].addr), 32'd80);
      check("b80_addr1", 32'(wq[1].addr), 32'd84);
      check("b80_addr2", 32'(wq[2].addr), 32'd88);
      check("b80_data2", wq[2].data, 32'h3333_0003);
    end
    check("b80_words", 32'(words1), 32'd3);
    check("b80_done", 32'(done1), 32'd1);

    // LOAD_BASE = 80, N = 45 exceeds the 44-word limit.
    do_reset(1'b1);
    send_word(32'd45, 0);
    wait_end();
    check("b80_n45_err", 32'(err1), 32'd1);
    check("b80_n45_nwr", 32'(wq.size()), 32'd0);

    // LOAD_BASE = 80, N = 44 fills exactly to address 252.
    do_reset(1'b1);
    send_word(32'd44, 0);
    for (int i = 0; i < 44; i++) send_word(32'hA500_0000 + 32'(i), 0);
    wait_end();
    check("b80_n44_err", 32'(err1), 32'd0);
    check("b80_n44_nwr", 32'(wq.size()), 32'd44);
    if (wq.size() == 44) begin
      check("b80_n44_last_addr", 32'(wq[43].addr), 32'd252);
      check("b80_n44_last_data", wq[43].data, 32'hA500_002B);
    end
    check("b80_n44_words", 32'(words1), 32'd44);
    check("b80_n44_done", 32'(done1), 32'd1);

    // Reset in the middle of word 1, then a fresh single-word load.
    do_reset(1'b0);
    send_word(32'd2, 0);
    send_word(32'h0000_1234, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("mid_words_before", 32'(words0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ready", 32'(ready0), 32'd0);
    check("mid_we",    32'(we0),    32'd0);
    check("mid_addr",  32'(addr0),  32'd0);
    check("mid_wdata", wdata0,      32'd0);
    check("mid_cpu",   32'(cpu0),   32'd0);
    check("mid_words", 32'(words0), 32'd0);
    do_reset(1'b0);
    send_word(32'd1, 0);
    send_word(32'h00A0_0093, 0);
    wait_end();
    check("fresh_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      check("fresh_addr", 32'(wq[0].addr), 32'd0);
      check("fresh_data", wq[0].data, 32'h00A0_0093);
    end
    check("fresh_done", 32'(done0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
